// File: rtl/unidade_load_store.sv
// ============================================================================
// unidade_load_store: one request/ack data-memory access with lane steering,
// alignment check and load extension. Optional macro: LS_TIMEOUT_EN.
// Revision 1.0
// ============================================================================
`default_nettype none

module unidade_load_store #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [63:0] addr,
  input  logic [63:0] store_data,
  input  logic        is_store,
  input  logic [1:0]  size,
  input  logic        load_unsigned,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wstrb,
  input  logic [63:0] mem_rdata,
  input  logic        mem_ack,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [63:0] load_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state;
  logic [2:0]  off_q;
  logic [1:0]  size_q;
  logic        uns_q;

  logic        misaligned;
  logic [7:0]  strb_base;
  logic [7:0]  lane_strb;
  logic [63:0] lane_wdata;
  logic [63:0] shifted;
  logic [63:0] load_ext;

`ifdef LS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt;
`endif

  always_comb begin
    misaligned = 1'b0;
    strb_base  = 8'h01;
    case (size)
      2'd0: begin misaligned = 1'b0;          strb_base = 8'h01; end
      2'd1: begin misaligned = addr[0];       strb_base = 8'h03; end
      2'd2: begin misaligned = |addr[1:0];    strb_base = 8'h0F; end
      default: begin misaligned = |addr[2:0]; strb_base = 8'hFF; end
    endcase
    lane_strb  = strb_base << addr[2:0];
    lane_wdata = store_data << {addr[2:0], 3'b000};
  end

  // Load extraction uses the offset/size captured at start, not the live inputs.
  always_comb begin
    shifted  = mem_rdata >> {off_q, 3'b000};
    load_ext = shifted;
    case (size_q)
      2'd0: load_ext = uns_q ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
      2'd1: load_ext = uns_q ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      2'd2: load_ext = uns_q ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      default: load_ext = shifted;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      off_q     <= 3'd0;
      size_q    <= 2'd0;
      uns_q     <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 64'd0;
      mem_wdata <= 64'd0;
      mem_wstrb <= 8'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      load_data <= 64'd0;
`ifdef LS_TIMEOUT_EN
      wait_cnt  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            off_q  <= addr[2:0];
            size_q <= size;
            uns_q  <= load_unsigned;
            busy   <= 1'b1;
            if (misaligned) begin
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state     <= ACCESS;
              mem_req   <= 1'b1;
              mem_we    <= is_store;
              mem_addr  <= {addr[63:3], 3'b000};
              mem_wdata <= lane_wdata;
              mem_wstrb <= is_store ? lane_strb : 8'd0;
`ifdef LS_TIMEOUT_EN
              wait_cnt  <= '0;
`endif
            end
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            state     <= DONE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wstrb <= 8'd0;
            done      <= 1'b1;
            err       <= 1'b0;
            if (!mem_we) load_data <= load_ext;
          end
`ifdef LS_TIMEOUT_EN
          else if (wait_cnt == CW'(TIMEOUT_CYCLES)) begin
            state     <= DONE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wstrb <= 8'd0;
            done      <= 1'b1;
            err       <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          err   <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_unidade_load_store.sv
// ============================================================================
// tb_unidade_load_store: randomized and directed bench with a byte-level model.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_unidade_load_store;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [63:0] addr = '0;
  logic [63:0] store_data = '0;
  logic        is_store = 1'b0;
  logic [1:0]  size = '0;
  logic        load_unsigned = 1'b0;
  logic        mem_req, mem_we;
  logic [63:0] mem_addr, mem_wdata;
  logic [7:0]  mem_wstrb;
  logic [63:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        busy, done, err;
  logic [63:0] load_data;

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_ld = '0;

  // Results of the last run_access
  int          r_done_cyc, r_done_cnt;
  bit          r_err, r_req_ever, r_stable, r_ctl_ok;
  logic [63:0] r_addr, r_wdata;
  logic [7:0]  r_strb;
  logic        r_we;

  unidade_load_store #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .addr(addr), .store_data(store_data),
    .is_store(is_store), .size(size), .load_unsigned(load_unsigned),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busy(busy), .done(done), .err(err), .load_data(load_data)
  );

  always #5 clk = ~clk;

  function automatic int nbytes(input logic [1:0] sz);
    return 1 << sz;
  endfunction

  function automatic bit model_mis(input logic [63:0] a, input logic [1:0] sz);
    return (a % nbytes(sz)) != 0;
  endfunction

  function automatic logic [7:0] model_strb(input logic [63:0] a, input logic [1:0] sz);
    logic [7:0] s = '0;
    for (int i = 0; i < nbytes(sz); i++)
      if (a[2:0] + i < 8) s[a[2:0] + i] = 1'b1;
    return s;
  endfunction

  function automatic logic [63:0] model_wdata(input logic [63:0] a, input logic [63:0] sd);
    logic [63:0] w = '0;
    int o = int'(a[2:0]);
    for (int j = 0; j < 8; j++)
      if (j >= o) w[8*j +: 8] = sd[8*(j-o) +: 8];
    return w;
  endfunction

  function automatic logic [63:0] model_load(input logic [63:0] a, input logic [1:0] sz,
                                             input logic uns, input logic [63:0] rd);
    logic [63:0] v = '0;
    int o = int'(a[2:0]);
    int n = nbytes(sz);
    for (int i = 0; i < n; i++) v = v | (64'(rd[8*(o+i) +: 8]) << (8*i));
    if (!uns && n < 8 && v >= (64'd1 << (8*n - 1))) v = v - (64'd1 << (8*n));
    return v;
  endfunction

  // Issues one access and records what the memory port and control outputs did.
  task automatic run_access(input logic [63:0] a, input logic [63:0] sd, input logic st,
                            input logic [1:0] sz, input logic uns, input int ack_at,
                            input logic [63:0] rd, input bit extra_start);
    addr = a; store_data = sd; is_store = st; size = sz; load_unsigned = uns;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    addr = {$urandom, $urandom}; store_data = {$urandom, $urandom};
    is_store = 1'($urandom); size = 2'($urandom); load_unsigned = 1'($urandom);
    r_done_cyc = 0; r_done_cnt = 0; r_err = 0; r_req_ever = 0; r_stable = 1; r_ctl_ok = 1;
    r_addr = '0; r_wdata = '0; r_strb = '0; r_we = 1'b0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (mem_req) begin
        if (!r_req_ever) begin
          r_addr = mem_addr; r_wdata = mem_wdata; r_strb = mem_wstrb; r_we = mem_we;
        end else if (mem_addr !== r_addr || mem_wdata !== r_wdata ||
                     mem_wstrb !== r_strb || mem_we !== r_we) begin
          r_stable = 0;
        end
        r_req_ever = 1;
      end
      if (done === 1'b1) begin
        if (r_done_cnt == 0) begin r_done_cyc = cyc; r_err = err; end
        r_done_cnt++;
      end
      if (busy !== ((r_done_cnt == 0) || (done && r_done_cnt == 1))) r_ctl_ok = 0;
      if (err === 1'b1 && done !== 1'b1) r_ctl_ok = 0;
      mem_ack = (cyc == ack_at);
      mem_rdata = mem_ack ? rd : {$urandom, $urandom};
      start = extra_start && (cyc == 2);
      if (r_done_cnt > 0 && cyc >= r_done_cyc + 3) break;
      @(posedge clk); #1;
    end
    mem_ack = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    checks++; if ({mem_req, mem_we, busy, done, err} !== 5'b0) begin failures++;
      $display("FAIL reset_ctrl got=%b exp=00000", {mem_req, mem_we, busy, done, err}); end
    checks++; if ({mem_addr, mem_wdata, mem_wstrb, load_data} !== '0) begin failures++;
      $display("FAIL reset_data addr=%h wdata=%h strb=%h ld=%h exp=0", mem_addr, mem_wdata, mem_wstrb, load_data); end
    @(posedge clk); #1;
    reset = 1'b0;
    exp_ld = '0;
  endtask

  task automatic test_load_double;
    run_access(64'h1000, 64'h0, 1'b0, 2'd3, 1'b1, 1, 64'h8877665544332211, 1'b0);
    exp_ld = 64'h8877665544332211;
    checks++; if (r_done_cyc !== 2) begin failures++; $display("FAIL ld64_latency got=%0d exp=2", r_done_cyc); end
    checks++; if (r_addr !== 64'h1000) begin failures++; $display("FAIL ld64_addr got=%h exp=1000", r_addr); end
    checks++; if (r_err !== 1'b0) begin failures++; $display("FAIL ld64_err got=%b exp=0", r_err); end
    checks++; if (load_data !== exp_ld) begin failures++; $display("FAIL ld64_data got=%h exp=%h", load_data, exp_ld); end
  endtask

  task automatic test_byte_load_sign;
    run_access(64'h1005, 64'h0, 1'b0, 2'd0, 1'b0, 1, 64'h0000_F000_0000_0000, 1'b0);
    checks++; if (load_data !== 64'hFFFF_FFFF_FFFF_FFF0) begin failures++;
      $display("FAIL lb_signed got=%h exp=fffffffffffffff0", load_data); end
    run_access(64'h1005, 64'h0, 1'b0, 2'd0, 1'b1, 1, 64'h0000_F000_0000_0000, 1'b0);
    exp_ld = 64'hF0;
    checks++; if (load_data !== exp_ld) begin failures++; $display("FAIL lb_unsigned got=%h exp=%h", load_data, exp_ld); end
  endtask

  task automatic test_half_store;
    run_access(64'h2006, 64'hABCD, 1'b1, 2'd1, 1'b0, 2, 64'h0, 1'b0);
    checks++; if (r_we !== 1'b1 || r_strb !== 8'hC0) begin failures++;
      $display("FAIL sh_we_strb got=%b/%h exp=1/c0", r_we, r_strb); end
    checks++; if (r_wdata[63:48] !== 16'hABCD) begin failures++; $display("FAIL sh_wdata got=%h exp=abcd", r_wdata[63:48]); end
    checks++; if (r_addr !== 64'h2000) begin failures++; $display("FAIL sh_addr got=%h exp=2000", r_addr); end
    checks++; if (load_data !== exp_ld) begin failures++; $display("FAIL sh_ld_hold got=%h exp=%h", load_data, exp_ld); end
  endtask

  task automatic test_misaligned;
    run_access(64'h3002, 64'h0, 1'b0, 2'd2, 1'b0, 1, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0);
    checks++; if (r_done_cyc !== 1 || r_err !== 1'b1) begin failures++;
      $display("FAIL mis_done got=cyc%0d err%b exp=cyc1 err1", r_done_cyc, r_err); end
    checks++; if (r_req_ever !== 1'b0) begin failures++; $display("FAIL mis_req got=%b exp=0", r_req_ever); end
    checks++; if (load_data !== exp_ld) begin failures++; $display("FAIL mis_ld_hold got=%h exp=%h", load_data, exp_ld); end
  endtask

  task automatic test_delayed_ack;
    logic [63:0] rd = 64'h1234_5678_9ABC_DEF0;
    run_access(64'h4010, 64'h0, 1'b0, 2'd2, 1'b0, 5, rd, 1'b1);
    exp_ld = model_load(64'h4010, 2'd2, 1'b0, rd);
    checks++; if (r_done_cyc !== 6 || r_done_cnt !== 1) begin failures++;
      $display("FAIL delay_done got=cyc%0d cnt%0d exp=cyc6 cnt1", r_done_cyc, r_done_cnt); end
    checks++; if (r_stable !== 1'b1 || r_ctl_ok !== 1'b1) begin failures++;
      $display("FAIL delay_hold got=stable%b ctl%b exp=1/1", r_stable, r_ctl_ok); end
    checks++; if (load_data !== exp_ld) begin failures++; $display("FAIL delay_data got=%h exp=%h", load_data, exp_ld); end
  endtask

  task automatic test_timeout;
`ifdef LS_TIMEOUT_EN
    run_access(64'h5000, 64'h0, 1'b0, 2'd3, 1'b0, 0, 64'h0, 1'b0);
    checks++; if (r_done_cyc !== TO + 2 || r_err !== 1'b1) begin failures++;
      $display("FAIL timeout got=cyc%0d err%b exp=cyc%0d err1", r_done_cyc, r_err, TO + 2); end
    checks++; if (load_data !== exp_ld) begin failures++; $display("FAIL timeout_ld got=%h exp=%h", load_data, exp_ld); end
`endif
  endtask

  task automatic test_reset_mid_access;
    addr = 64'h6000; size = 2'd3; is_store = 1'b0; load_unsigned = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    exp_ld = '0;
    checks++; if (mem_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin failures++;
      $display("FAIL rst_mid got=req%b busy%b done%b exp=000", mem_req, busy, done); end
    @(posedge clk); #1;
    reset = 1'b0;
    mem_ack = 1'b1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    checks++; if ({mem_req, busy, done, load_data} !== '0) begin failures++;
      $display("FAIL rst_late_ack got=req%b busy%b done%b ld=%h exp=0", mem_req, busy, done, load_data); end
    run_access(64'h6008, 64'h0, 1'b0, 2'd1, 1'b0, 1, 64'h0000_0000_0000_8001, 1'b0);
    exp_ld = 64'hFFFF_FFFF_FFFF_8001;
    checks++; if (r_done_cyc !== 2 || load_data !== exp_ld) begin failures++;
      $display("FAIL rst_recover got=cyc%0d ld=%h exp=cyc2 ld=%h", r_done_cyc, load_data, exp_ld); end
  endtask

  task automatic test_random;
    for (int n = 0; n < 40; n++) begin
      logic [63:0] a = {$urandom, $urandom};
      logic [63:0] sd = {$urandom, $urandom};
      logic [63:0] rd = {$urandom, $urandom};
      logic [1:0]  sz = 2'($urandom_range(0, 3));
      logic        st = 1'($urandom_range(0, 1));
      logic        uns = 1'($urandom_range(0, 1));
      int          ack_at = $urandom_range(1, 4);
      bit          mis;
      if ($urandom_range(0, 3) != 0) a = a & ~64'(nbytes(sz) - 1);
      mis = model_mis(a, sz);
      run_access(a, sd, st, sz, uns, ack_at, rd, 1'b0);
      checks++; if (r_done_cnt !== 1 || r_ctl_ok !== 1'b1) begin failures++;
        $display("FAIL rnd%0d_ctl got=cnt%0d ctl%b exp=1/1", n, r_done_cnt, r_ctl_ok); end
      if (mis) begin
        checks++; if (r_done_cyc !== 1 || r_err !== 1'b1 || r_req_ever !== 1'b0) begin failures++;
          $display("FAIL rnd%0d_mis got=cyc%0d err%b req%b exp=1/1/0", n, r_done_cyc, r_err, r_req_ever); end
      end else begin
        if (!st) exp_ld = model_load(a, sz, uns, rd);
        checks++; if (r_done_cyc !== ack_at + 1 || r_err !== 1'b0 || r_stable !== 1'b1) begin failures++;
          $display("FAIL rnd%0d_timing got=cyc%0d err%b stable%b exp=%0d/0/1", n, r_done_cyc, r_err, r_stable, ack_at + 1); end
        checks++; if (r_addr !== {a[63:3], 3'b000} || r_we !== st) begin failures++;
          $display("FAIL rnd%0d_addr got=%h we%b exp=%h we%b", n, r_addr, r_we, {a[63:3], 3'b000}, st); end
        checks++; if (r_strb !== (st ? model_strb(a, sz) : 8'h00)) begin failures++;
          $display("FAIL rnd%0d_strb got=%h exp=%h", n, r_strb, st ? model_strb(a, sz) : 8'h00); end
        if (st) begin
          checks++; if (r_wdata !== model_wdata(a, sd)) begin failures++;
            $display("FAIL rnd%0d_wdata got=%h exp=%h", n, r_wdata, model_wdata(a, sd)); end
        end
      end
      checks++; if (load_data !== exp_ld) begin failures++;
        $display("FAIL rnd%0d_ld got=%h exp=%h", n, load_data, exp_ld); end
    end
  endtask

  initial begin
    test_reset;
    test_load_double;
    test_byte_load_sign;
    test_half_store;
    test_misaligned;
    test_delayed_ack;
    test_timeout;
    test_reset_mid_access;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
